// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, legal parameter ranges and a data-mask helper.
// Intended for reuse by uart_tx and a future uart_rx.
package uart_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StArmed  = 3'd1;
    localparam logic [2:0] StStart  = 3'd2;
    localparam logic [2:0] StData   = 3'd3;
    localparam logic [2:0] StParity = 3'd4;
    localparam logic [2:0] StStop   = 3'd5;

    localparam int unsigned DataBitsMin = 5;
    localparam int unsigned DataBitsMax = 8;
    localparam int unsigned StopBitsMin = 1;
    localparam int unsigned StopBitsMax = 2;

    // Keeps only the low 'bits' bits of a byte.
    function automatic logic [7:0] data_mask(input int unsigned bits);
        return 8'hFF >> (8 - bits);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit (odd when PARITY_ODD=1, else even).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    if (DATA_BITS < DataBitsMin || DATA_BITS > DataBitsMax) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS out of range");
    end
    if (STOP_BITS < StopBitsMin || STOP_BITS > StopBitsMax) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS out of range");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
    localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       tx_q, tx_d;
    logic       init_q;
    logic [7:0] data_in;
    logic       accept;

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    // init_q holds tx_ready low until the first edge after reset is released.
    assign tx_ready = init_q && (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign tx       = tx_q;
    assign accept   = tx_valid && tx_ready;
    assign data_in  = tx_data & data_mask(DATA_BITS);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                // A tick in the accept cycle is deliberately ignored: ARMED waits for the next.
                if (accept) begin
                    state_d = StArmed;
                    shift_d = data_in;
                    cnt_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^data_in) ^ (PARITY_ODD != 0);
`endif
                end
            end
            StArmed: begin
                if (baud_tick) begin
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = 3'd0;
                end
            end
            StData: begin
                if (baud_tick) begin
                    if (cnt_q == LastData) begin
                        cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_tick) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                    cnt_d   = 3'd0;
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (baud_tick) begin
                    if (cnt_q == LastStop) begin
                        state_d = StIdle;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
            tx_q    <= 1'b1;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            init_q  <= 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_BITS, 8, data bits per frame, legal 5..8.
REQ-002 Parameter: STOP_BITS, 1, stop bits per frame, legal 1 or 2.
REQ-003 Parameter: PARITY_ODD, 0, 1 = odd parity, 0 = even; effective only with UART_TX_PARITY_EN.
REQ-004 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: baud_tick  input  1  single-clk-wide pulse, once per bit period, from a prescaler at the top level.
REQ-007 Port: tx_data  input  8  byte to send; bits above DATA_BITS-1 ignored.
REQ-008 Port: tx_valid  input  1  tx_data is valid.
REQ-009 Port: tx_ready  output  1  block can accept a byte this cycle.
REQ-010 Port: tx  output  1  serial line, idle high, registered.
REQ-011 Port: busy  output  1  frame accepted and not yet finished.

Function
REQ-012 Accept SHALL occur on a clk edge with tx_valid=1 and tx_ready=1; tx_data latched into shift register, tx_ready cleared next cycle.
REQ-013 States SHALL be IDLE, ARMED, START, DATA, PARITY, STOP; all transitions other than IDLE->ARMED occur only on cycles with baud_tick=1.
REQ-014 IDLE: tx=1, tx_ready=1, busy=0; accept -> ARMED.
REQ-015 ARMED: tx=1, busy=1; a baud_tick in the accept cycle is ignored; next baud_tick -> START, tx<=0.
REQ-016 START: on baud_tick -> DATA, tx<=bit 0 (LSB first), bit counter=0.
REQ-017 DATA: on baud_tick, counter<DATA_BITS-1 -> tx<=next bit, counter+1; counter==DATA_BITS-1 -> PARITY (macro defined, tx<=parity) or STOP (tx<=1).
REQ-018 PARITY: on baud_tick -> STOP, tx<=1.
REQ-019 STOP: held STOP_BITS tick periods; on the tick ending the last stop bit -> IDLE, tx stays 1, tx_ready=1 next cycle.
REQ-020 Each bit SHALL last exactly one baud_tick-to-baud_tick interval; tx changes only the cycle after a baud_tick.
REQ-021 Back-to-back frames SHALL be separated by at least one idle-high bit period (ARMED wait); no gapless chaining.
REQ-022 tx_valid while tx_ready=0 SHALL be ignored; tx_data changes after accept SHALL not affect the frame in flight.

Reset
REQ-023 Reset asserted SHALL immediately force: state IDLE, tx=1, tx_ready=0, busy=0, shift register and counters 0.
REQ-024 tx_ready SHALL rise on the first clk edge after reset deasserts.
REQ-025 Reset mid-frame SHALL abort the frame; line returns high with no further bits; byte discarded.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: PARITY state active; parity bit = XOR of the DATA_BITS data bits, inverted if PARITY_ODD=1.
REQ-027 Macro UART_TX_PARITY_EN undefined: PARITY state, parity logic and PARITY_ODD effect absent; DATA goes directly to STOP.

Structure
REQ-028 State encodings and the DATA_BITS/STOP_BITS legal-range constants SHALL live in shared package uart_pkg, for reuse by a future uart_rx.
REQ-029 No sub-module; bit timing comes from an external prescaler instance driving baud_tick.

Verification (baud_tick every 4 clks, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-030 Send 0x55 -> tx: 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each 4 clks; tx_ready back high 1 clk after stop-ending tick.
REQ-031 tx_valid held high with 0xA5 then 0x3C -> two frames, one idle-high bit period between, busy high through each frame.
REQ-032 UART_TX_PARITY_EN, send 0x07: PARITY_ODD=0 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame 11 bits.
REQ-033 STOP_BITS=2, send 0xFF -> stop high for 8 clks before tx_ready rises; DATA_BITS=5, send 0xE3 -> only bits 1,1,0,0,0 sent.
REQ-034 Reset pulse during data bit 3 of 0x00 -> tx=1 same cycle, busy=0, tx_ready=1 first edge after release, no further low bits.
REQ-035 Accept coincident with baud_tick -> start bit begins at the following tick, not the coincident one.
